clock_time_ctrl: RTL and testbench
==================================

CLOCK_TIME_CTRL -- requirements
Module: clock_time_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clk frequency in Hz; legal values are even and >= 4.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on SW and BTN_INC.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port SW  input  2  mode select, asynchronous to clk.
REQ-006 SHALL have port BTN_INC  input  1  increment button, asynchronous to clk, active-high level.
REQ-007 SHALL have ports SEG1..SEG6  output  7 each  active-low segments {g,f,e,d,c,b,a}, ordered SEG6=hour tens, SEG5=hour units, SEG4=min tens, SEG3=min units, SEG2=sec tens, SEG1=sec units.
REQ-008 SHALL have port SEC_TICK  output  1  single-cycle pulse on each seconds advance.

Function
REQ-009 SHALL pass SW and BTN_INC through SYNC_STAGES flops; all decisions use the synchronized values.
REQ-010 SHALL hold a prescaler counting 0..CLK_HZ-1 and wrapping to 0; tick asserts for the cycle in which prescaler = CLK_HZ-1.
REQ-011 SHALL implement FSM states RUN (SW=00), SET_H (SW=01), SET_M (SW=10) and HOLD (SW=11); state follows synchronized SW on the next edge from any state.
REQ-012 SHALL, in RUN, advance time on tick: sec 59->00 with carry to min, min 59->00 with carry to hour, hour 23->00; 23:59:59 -> 00:00:00.
REQ-013 SHALL keep time in six BCD digit registers; no binary-to-BCD conversion.
REQ-014 SHALL pulse SEC_TICK high for one cycle, in the same cycle the seconds register updates, and only in RUN.
REQ-015 SHALL, on the transition into SET_H or SET_M, clear the prescaler and seconds to 0 in that cycle.
REQ-016 SHALL, in SET_H, increment hour (23->00, no carry) on each rising edge of synchronized BTN_INC; in SET_M, increment minute (59->00, no carry to hour).
REQ-017 SHALL ignore BTN_INC in RUN and HOLD; button held high produces exactly one increment.
REQ-018 SHALL, in HOLD, freeze the prescaler and all time digits.
REQ-019 SHALL, on a cycle with both a state change and a tick or button edge, apply only the state change; the tick or edge is dropped.
REQ-020 SHALL define blink phase = 1 when prescaler >= CLK_HZ/2; in SET_H the hour digits, and in SET_M the minute digits, drive 7'h7F while blink phase = 1.
REQ-021 SHALL register segment outputs: SEGn reflects the digit value one cycle after the digit register changes.
REQ-022 SHALL use the encoding 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, active-low); codes 10-15 give 7'h7F.

Reset
REQ-023 SHALL, while RST is high, asynchronously force state RUN, prescaler 0, all digits 0, all synchronizer flops 0, button-edge history 0, and SEC_TICK 0.
REQ-024 SHALL, while RST is high, drive SEG1..SEG6 to 7'h40 (shows "0").
REQ-025 SHALL, when reset asserts mid-operation, discard any partial prescaler count and pending edge; the first tick after release arrives CLK_HZ cycles after the first non-reset edge.

Structure
REQ-026 SHALL place in a shared package: the FSM state type, the mode encodings for SW, the BCD-to-segment table, and the blank constant 7'h7F.
REQ-027 SHALL instantiate six copies of one sub-module, seg7_bcd_decoder (4-bit BCD in, 7-bit active-low out, combinational), with the registering done in clock_time_ctrl.
REQ-028 SHALL keep the synchronizers, prescaler, FSM and digit counters in clock_time_ctrl; target 150-300 lines total.

Verification (CLK_HZ=10, SYNC_STAGES=2)
REQ-029 SHALL check reset: RST=1 gives SEG1..SEG6 = 40 and SEC_TICK = 0; after release with SW=00, the first SEC_TICK arrives 10 cycles later and SEG1 = 79 one cycle after that.
REQ-030 SHALL check rollover: preload 23:59:59 via set mode, then run; one tick gives all digits 0, SEG6..SEG1 = 40, and one SEC_TICK.
REQ-031 SHALL check set mode: SW=01 with 3 BTN_INC pulses from hour 22 gives hour 01 and unchanged minutes; SW=10 with BTN_INC held 50 cycles gives exactly one minute increment.
REQ-032 SHALL check HOLD: SW=11 for 40 cycles gives no SEC_TICK and unchanged digits; returning to SW=00 resumes from the frozen prescaler value.
REQ-033 SHALL check collisions: SW change coinciding with a tick drops that tick; a BTN_INC edge coinciding with the SET_H entry causes no increment.
REQ-034 SHALL check blink and reset mid-operation: in SET_M, SEG4/SEG3 = 7F for prescaler 5..9; RST asserted at prescaler 7 restores REQ-023/REQ-024 values immediately.

Source files
------------

// File: rtl/clock_time_ctrl_pkg.sv
// Shared types and constants for the HH:MM:SS clock: FSM states, SW mode
// encodings, BCD time record and the active-low seven-segment table.
package clock_time_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SET_H = 2'b01;
  localparam logic [1:0] MODE_SET_M = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Segment codes {g,f,e,d,c,b,a}, entry 9 first so SEG_TABLE[d] is digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] mn_t;
    logic [3:0] mn_u;
    logic [3:0] sc_t;
    logic [3:0] sc_u;
  } bcd_time_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_seg7_bcd_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal
// codes produce a blank digit.
module seg7_bcd_decoder
  import clock_time_ctrl_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/clock_time_ctrl.sv
// 24-hour BCD clock with run / set-hour / set-minute / hold modes, a
// one-second prescaler and registered, blinking seven-segment outputs.
module clock_time_ctrl
  import clock_time_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] SW,
  input  logic       BTN_INC,
  output logic [6:0] SEG1,
  output logic [6:0] SEG2,
  output logic [6:0] SEG3,
  output logic [6:0] SEG4,
  output logic [6:0] SEG5,
  output logic [6:0] SEG6,
  output logic       SEC_TICK
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  logic [SYNC_STAGES-1:0][1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0]      btn_sync_q;
  logic                        btn_prev_q;
  state_e                      state_q, state_d;
  logic [PW-1:0]               presc_q, presc_d;
  bcd_time_t                   time_q, time_d;
  logic                        sec_tick_q, sec_tick_d;
  logic [5:0][6:0]             seg_q, seg_d;

  logic [1:0] sw_s;
  logic       btn_s;
  logic       btn_edge_s;
  logic       tick_s;
  logic       state_chg_s;
  logic       blink_s;
  logic [5:0][6:0] dec_s;

  function automatic bcd_time_t inc_hour(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hr_t == 4'd2 && t.hr_u == 4'd3) begin
      r.hr_t = 4'd0;
      r.hr_u = 4'd0;
    end else if (t.hr_u == 4'd9) begin
      r.hr_u = 4'd0;
      r.hr_t = t.hr_t + 4'd1;
    end else begin
      r.hr_u = t.hr_u + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t inc_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.mn_u != 4'd9) begin
      r.mn_u = t.mn_u + 4'd1;
    end else if (t.mn_t != 4'd5) begin
      r.mn_u = 4'd0;
      r.mn_t = t.mn_t + 4'd1;
    end else begin
      r.mn_u = 4'd0;
      r.mn_t = 4'd0;
    end
    return r;
  endfunction

  function automatic bcd_time_t adv_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sc_u != 4'd9) begin
      r.sc_u = t.sc_u + 4'd1;
    end else if (t.sc_t != 4'd5) begin
      r.sc_u = 4'd0;
      r.sc_t = t.sc_t + 4'd1;
    end else begin
      r.sc_u = 4'd0;
      r.sc_t = 4'd0;
      r = inc_min(r);
      if (t.mn_t == 4'd5 && t.mn_u == 4'd9) begin
        r = inc_hour(r);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Input synchronizer chains for SW and BTN_INC.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sw_sync_q  <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_sync_q[0]  <= SW;
      btn_sync_q[0] <= BTN_INC;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_q[i]  <= sw_sync_q[i-1];
        btn_sync_q[i] <= btn_sync_q[i-1];
      end
    end
  end

  assign sw_s        = sw_sync_q[SYNC_STAGES-1];
  assign btn_s       = btn_sync_q[SYNC_STAGES-1];
  assign btn_edge_s  = btn_s & ~btn_prev_q;
  assign tick_s      = (presc_q == PRESC_MAX);
  assign state_chg_s = (state_d != state_q);
  assign blink_s     = (presc_q >= PRESC_HALF);

  // Mode FSM, prescaler and digit counters; a mode change wins over any tick or edge.
  always_comb begin
    state_d    = ST_RUN;
    presc_d    = presc_q;
    time_d     = time_q;
    sec_tick_d = 1'b0;

    case (sw_s)
      MODE_RUN:   state_d = ST_RUN;
      MODE_SET_H: state_d = ST_SET_H;
      MODE_SET_M: state_d = ST_SET_M;
      MODE_HOLD:  state_d = ST_HOLD;
      default:    state_d = ST_RUN;
    endcase

    if (state_q == ST_HOLD) begin
      presc_d = presc_q;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (state_chg_s) begin
      if (state_d == ST_SET_H || state_d == ST_SET_M) begin
        presc_d     = '0;
        time_d.sc_t = 4'd0;
        time_d.sc_u = 4'd0;
      end else begin
        time_d = time_q;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_s) begin
            time_d     = adv_sec(time_q);
            sec_tick_d = 1'b1;
          end else begin
            time_d = time_q;
          end
        end
        ST_SET_H: begin
          if (btn_edge_s) begin
            time_d = inc_hour(time_q);
          end else begin
            time_d = time_q;
          end
        end
        ST_SET_M: begin
          if (btn_edge_s) begin
            time_d = inc_min(time_q);
          end else begin
            time_d = time_q;
          end
        end
        ST_HOLD: time_d = time_q;
        default: time_d = time_q;
      endcase
    end
  end

  // Control and time state registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= ST_RUN;
      presc_q    <= '0;
      time_q     <= '0;
      btn_prev_q <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      time_q     <= time_d;
      btn_prev_q <= btn_s;
      sec_tick_q <= sec_tick_d;
    end
  end

  seg7_bcd_decoder u_dec_hr_t (.bcd_i(time_q.hr_t), .seg_o(dec_s[5]));
  seg7_bcd_decoder u_dec_hr_u (.bcd_i(time_q.hr_u), .seg_o(dec_s[4]));
  seg7_bcd_decoder u_dec_mn_t (.bcd_i(time_q.mn_t), .seg_o(dec_s[3]));
  seg7_bcd_decoder u_dec_mn_u (.bcd_i(time_q.mn_u), .seg_o(dec_s[2]));
  seg7_bcd_decoder u_dec_sc_t (.bcd_i(time_q.sc_t), .seg_o(dec_s[1]));
  seg7_bcd_decoder u_dec_sc_u (.bcd_i(time_q.sc_u), .seg_o(dec_s[0]));

  // Blank the digits being edited during the second half of each second.
  always_comb begin
    seg_d = dec_s;
    if (state_q == ST_SET_H && blink_s) begin
      seg_d[5] = SEG_BLANK;
      seg_d[4] = SEG_BLANK;
    end else if (state_q == ST_SET_M && blink_s) begin
      seg_d[3] = SEG_BLANK;
      seg_d[2] = SEG_BLANK;
    end else begin
      seg_d = dec_s;
    end
  end

  // Registered segment drivers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      seg_q <= {6{SEG_ZERO}};
    end else begin
      seg_q <= seg_d;
    end
  end

  assign SEG1     = seg_q[0];
  assign SEG2     = seg_q[1];
  assign SEG3     = seg_q[2];
  assign SEG4     = seg_q[3];
  assign SEG5     = seg_q[4];
  assign SEG6     = seg_q[5];
  assign SEC_TICK = sec_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scenario bench for clock_time_ctrl at CLK_HZ=10: expected displays are
// queued from a bench-side time model and popped when the DUT shows them.
module tb_clock_time_ctrl;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       RST;
  logic [1:0] SW;
  logic       BTN_INC;
  logic [6:0] SEG1, SEG2, SEG3, SEG4, SEG5, SEG6;
  logic       SEC_TICK;
  logic [41:0] seg_bus;

  int checks   = 0;
  int failures = 0;
  int hh = 0, mm = 0, ss = 0;
  int n;
  int ticks;
  logic [41:0] exp_q [$];
  logic [41:0] exp_v;

  clock_time_ctrl #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(2)) dut (
    .clk(clk), .RST(RST), .SW(SW), .BTN_INC(BTN_INC),
    .SEG1(SEG1), .SEG2(SEG2), .SEG3(SEG3), .SEG4(SEG4), .SEG5(SEG5), .SEG6(SEG6),
    .SEC_TICK(SEC_TICK)
  );

  always #5 clk = ~clk;

  assign seg_bus = {SEG6, SEG5, SEG4, SEG3, SEG2, SEG1};

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] seg_of(input int h, input int m, input int s);
    return {enc(4'(h / 10)), enc(4'(h % 10)), enc(4'(m / 10)),
            enc(4'(m % 10)), enc(4'(s / 10)), enc(4'(s % 10))};
  endfunction

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // SW passes two synchronizer flops, so the state follows on the third edge.
  task automatic set_sw(input logic [1:0] v);
    SW = v;
    step(3);
  endtask

  task automatic press();
    BTN_INC = 1'b1;
    step(3);
    BTN_INC = 1'b0;
    step(3);
  endtask

  task automatic wait_tick(input int bound, output int cnt);
    cnt = bound + 1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (SEC_TICK === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; SW = 2'b00; BTN_INC = 1'b0;
    step(3);
    exp_q.push_back(seg_of(0, 0, 0));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL reset_seg got=%h exp=%h", seg_bus, exp_v); end
    checks++;
    if (SEC_TICK !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", SEC_TICK); end
    RST = 1'b0;
    wait_tick(30, n);
    checks++;
    if (n != 10) begin failures++; $display("FAIL first_tick_latency got=%0d exp=10", n); end
    ss = 1;
    exp_q.push_back(seg_of(hh, mm, ss));
    step(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL first_second_seg got=%h exp=%h", seg_bus, exp_v); end
    checks++;
    if (SEC_TICK !== 1'b0) begin failures++; $display("FAIL tick_single_cycle got=%b exp=0", SEC_TICK); end
  endtask

  task automatic test_set_mode();
    set_sw(2'b10); ss = 0;
    repeat (7) press();
    mm = 7;
    set_sw(2'b01);
    repeat (22) press();
    hh = 22;
    set_sw(2'b11); step(1);
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL set_hour_22 got=%h exp=%h", seg_bus, exp_v); end
    set_sw(2'b01);
    repeat (3) press();
    hh = 1;
    set_sw(2'b11); step(1);
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL set_hour_wrap got=%h exp=%h", seg_bus, exp_v); end
    set_sw(2'b10);
    BTN_INC = 1'b1; step(50);
    BTN_INC = 1'b0; step(4);
    mm = 8;
    set_sw(2'b11); step(1);
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL set_min_held got=%h exp=%h", seg_bus, exp_v); end
  endtask

  task automatic test_rollover();
    set_sw(2'b01);
    repeat (22) press();
    hh = 23;
    set_sw(2'b10);
    repeat (51) press();
    mm = 59;
    set_sw(2'b00);
    for (int t = 1; t <= 59; t++) begin
      wait_tick(12, n);
      checks++;
      if ((t == 1) ? (n > 10) : (n != 10)) begin
        failures++; $display("FAIL rollover_tick_gap tick=%0d got=%0d exp=10", t, n);
      end
    end
    ss = 59;
    exp_q.push_back(seg_of(hh, mm, ss));
    step(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL rollover_235959 got=%h exp=%h", seg_bus, exp_v); end
    wait_tick(12, n);
    checks++;
    if (n != 9) begin failures++; $display("FAIL rollover_tick got=%0d exp=9", n); end
    hh = 0; mm = 0; ss = 0;
    exp_q.push_back(seg_of(hh, mm, ss));
    step(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL rollover_zero got=%h exp=%h", seg_bus, exp_v); end
    checks++;
    if (SEC_TICK !== 1'b0) begin failures++; $display("FAIL rollover_single_tick got=%b exp=0", SEC_TICK); end
  endtask

  task automatic test_hold();
    wait_tick(12, n);
    checks++;
    if (n != 9) begin failures++; $display("FAIL hold_pre_tick got=%0d exp=9", n); end
    ss = 1;
    SW = 2'b11;
    ticks = 0;
    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      if (SEC_TICK === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0) begin failures++; $display("FAIL hold_no_tick got=%0d exp=0", ticks); end
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL hold_frozen got=%h exp=%h", seg_bus, exp_v); end
    // Prescaler froze at 3: 3 sync edges, 6 counts to 9, then the tick edge.
    SW = 2'b00;
    wait_tick(20, n);
    checks++;
    if (n != 10) begin failures++; $display("FAIL hold_resume_phase got=%0d exp=10", n); end
    ss = 2;
  endtask

  task automatic test_collision();
    step(7);
    SW = 2'b11;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (SEC_TICK === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0) begin failures++; $display("FAIL collision_tick_count got=%0d exp=0", ticks); end
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL collision_tick_dropped got=%h exp=%h", seg_bus, exp_v); end
    SW = 2'b01; BTN_INC = 1'b1;
    step(6);
    BTN_INC = 1'b0;
    step(3);
    ss = 0;
    set_sw(2'b11); step(1);
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL collision_btn_dropped got=%h exp=%h", seg_bus, exp_v); end
  endtask

  task automatic test_blink_reset();
    set_sw(2'b10);
    repeat (5) press();
    mm = 5;
    set_sw(2'b01);
    repeat (4) press();
    hh = 4;
    set_sw(2'b10);
    // Prescaler is 0 here; the registered segments show the phase one cycle late.
    for (int j = 1; j <= 10; j++) begin
      exp_v = seg_of(hh, mm, ss);
      if (j - 1 >= CLK_HZ / 2) exp_v[27:14] = {14{1'b1}};
      exp_q.push_back(exp_v);
      step(1);
      exp_v = exp_q.pop_front();
      checks++;
      if (seg_bus !== exp_v) begin failures++; $display("FAIL blink_j%0d got=%h exp=%h", j, seg_bus, exp_v); end
    end
    step(7);
    RST = 1'b1; SW = 2'b00;
    #1;
    hh = 0; mm = 0; ss = 0;
    exp_q.push_back(seg_of(hh, mm, ss));
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL midreset_seg got=%h exp=%h", seg_bus, exp_v); end
    checks++;
    if (SEC_TICK !== 1'b0) begin failures++; $display("FAIL midreset_tick got=%b exp=0", SEC_TICK); end
    step(2);
    RST = 1'b0;
    wait_tick(30, n);
    checks++;
    if (n != 10) begin failures++; $display("FAIL midreset_first_tick got=%0d exp=10", n); end
    ss = 1;
    exp_q.push_back(seg_of(hh, mm, ss));
    step(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (seg_bus !== exp_v) begin failures++; $display("FAIL midreset_resume got=%h exp=%h", seg_bus, exp_v); end
  endtask

  initial begin
    test_reset();
    test_set_mode();
    test_rollover();
    test_hold();
    test_collision();
    test_blink_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
